interrupt_requester: RTL and testbench

INTERRUPT_REQUESTER -- requirements
Module: interrupt_requester

---
 rtl/interrupt_requester.sv | 143 ++++++++++++++
 tb/tb_interrupt_requester.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_requester.sv
// interrupt_requester
//   Turns rising edges on a set of external interrupt lines into a one-cycle
//   interrupt request to the CPU, reports which line is being serviced and
//   holds off further requests until the handler executes RETURN.
//
//   Optional feature: define INTR_REQUESTER_MASK_EN to add a per-line mask
//   register (maskData/maskWrite). Without it every line is eligible.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous active-high reset
//   irqLines       external interrupt lines, synchronous to clock
//   intrEnable     CPU interrupt-enable state (only consulted in IDLE)
//   memInstOpcode  opcode [31:26] of the instruction in the memory stage
//   maskData       new mask value (mask feature only)
//   maskWrite      load mask register from maskData (mask feature only)
//   intr           one-cycle interrupt request pulse
//   intrCause      index of the serviced line, zero-extended
//   busy           high while a request is outstanding or in service
module interrupt_requester #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_LINES   = 4,
  parameter int CAUSE_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_LINES-1:0]  irqLines,
  input  logic                  intrEnable,
  input  logic [5:0]            memInstOpcode,
`ifdef INTR_REQUESTER_MASK_EN
  input  logic [NUM_LINES-1:0]  maskData,
  input  logic                  maskWrite,
`endif
  output logic                  intr,
  output logic [DATA_WIDTH-1:0] intrCause,
  output logic                  busy
);

  localparam logic [5:0] OP_RETURN = 6'b101100;

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    SERVICE
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_LINES-1:0]   irq_p0, irq_p1;
  logic [NUM_LINES-1:0]   rise_p1;
  logic [NUM_LINES-1:0]   pending_q, pending_d;
  logic [NUM_LINES-1:0]   eligible;
  logic [NUM_LINES-1:0]   clr_sel;
  logic [CAUSE_WIDTH-1:0] cause_q, sel_idx;
  logic                   sel_found;
  logic                   ret;
  logic                   load_cause;

  // Stage p0/p1: two registered copies of the lines. Reset loads ones so a
  // line already high when reset releases never looks like a new edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_p0 <= '1;
      irq_p1 <= '1;
    end else begin
      irq_p0 <= irqLines;
      irq_p1 <= irq_p0;
    end
  end

  assign rise_p1 = irq_p0 & ~irq_p1;

`ifdef INTR_REQUESTER_MASK_EN
  logic [NUM_LINES-1:0] mask_q;

  always_ff @(posedge clock) begin
    if (reset)          mask_q <= '1;
    else if (maskWrite) mask_q <= maskData;
  end

  // Masked lines still collect pending bits; they just cannot start a request.
  assign eligible = pending_q & mask_q;
`else
  assign eligible = pending_q;
`endif

  // Lowest eligible index wins: scan downward so the last hit is the lowest.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_found = 1'b1;
        sel_idx   = CAUSE_WIDTH'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) begin
      clr_sel[i] = (cause_q == CAUSE_WIDTH'(i));
    end
  end

  assign ret = (state_q == SERVICE) && (memInstOpcode == OP_RETURN);

  // A fresh edge on the line being returned from is OR-ed in after the
  // clear, so it survives and gets serviced again.
  assign pending_d = (pending_q & ~(ret ? clr_sel : '0)) | rise_p1;

  always_comb begin
    state_d    = state_q;
    load_cause = 1'b0;
    case (state_q)
      IDLE: begin
        if (intrEnable && sel_found) begin
          state_d    = REQUEST;
          load_cause = 1'b1;
        end
      end
      REQUEST: state_d = SERVICE;
      SERVICE: if (ret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p2: pending set, FSM state and the latched cause.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      if (load_cause) cause_q <= sel_idx;
    end
  end

  assign intr      = (state_q == REQUEST);
  assign busy      = (state_q != IDLE);
  assign intrCause = DATA_WIDTH'(cause_q);

endmodule

// File: tb/tb_interrupt_requester.sv
module tb_interrupt_requester;

  localparam int DATA_WIDTH  = 32;
  localparam int NUM_LINES   = 4;
  localparam int CAUSE_WIDTH = 2;
  localparam logic [5:0] OP_RETURN = 6'b101100;
  localparam logic [5:0] OP_HALT   = 6'b111111;
  localparam logic [5:0] OP_NOP    = 6'b000000;

  logic                  clock;
  logic                  reset;
  logic [NUM_LINES-1:0]  irqLines;
  logic                  intrEnable;
  logic [5:0]            memInstOpcode;
`ifdef INTR_REQUESTER_MASK_EN
  logic [NUM_LINES-1:0]  maskData;
  logic                  maskWrite;
`endif
  logic                  intr;
  logic [DATA_WIDTH-1:0] intrCause;
  logic                  busy;

  int total = 0;
  int bad   = 0;

  interrupt_requester #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_LINES  (NUM_LINES),
    .CAUSE_WIDTH(CAUSE_WIDTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .irqLines     (irqLines),
    .intrEnable   (intrEnable),
    .memInstOpcode(memInstOpcode),
`ifdef INTR_REQUESTER_MASK_EN
    .maskData     (maskData),
    .maskWrite    (maskWrite),
`endif
    .intr         (intr),
    .intrCause    (intrCause),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance until intr is seen or the budget runs out; cyc = -1 on timeout.
  task automatic wait_intr(input int limit, output int cyc);
    cyc = -1;
    for (int n = 1; n <= limit; n++) begin
      tick();
      if (intr === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic quiet_lines();
    irqLines = '0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    irqLines = '0;
    intrEnable = 1'b0;
    memInstOpcode = OP_NOP;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if (intr !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: intr=%b busy=%b, required 0 0", intr, busy);
    end
    total++;
    if (intrCause !== 32'd0) begin
      bad++;
      $display("FAIL reset_cause: got %0d, required 0", intrCause);
    end
    total++;
    if (dut.pending_q !== 4'b0000) begin
      bad++;
      $display("FAIL reset_pending: got %b, required 0000", dut.pending_q);
    end
    tick();
  endtask

  task automatic test_single();
    intrEnable = 1'b1;
    irqLines = 4'b0100;
    tick();
    tick();
    total++;
    if (intr !== 1'b0) begin
      bad++;
      $display("FAIL single_early: intr=%b one cycle before due, required 0", intr);
    end
    tick();
    total++;
    if (intr !== 1'b1 || intrCause !== 32'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_pulse: intr=%b cause=%0d busy=%b, required 1 2 1", intr, intrCause, busy);
    end
    tick();
    total++;
    if (intr !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_service: intr=%b busy=%b, required 0 1", intr, busy);
    end
    memInstOpcode = OP_RETURN;
    tick();
    memInstOpcode = OP_NOP;
    total++;
    if (busy !== 1'b0 || dut.pending_q !== 4'b0000) begin
      bad++;
      $display("FAIL single_return: busy=%b pending=%b, required 0 0000", busy, dut.pending_q);
    end
    quiet_lines();
  endtask

  task automatic test_priority();
    irqLines = 4'b1010;
    tick();
    tick();
    tick();
    total++;
    if (intr !== 1'b1 || intrCause !== 32'd1) begin
      bad++;
      $display("FAIL prio_first: intr=%b cause=%0d, required 1 1", intr, intrCause);
    end
    tick();
    memInstOpcode = OP_RETURN;
    tick();
    memInstOpcode = OP_NOP;
    total++;
    if (dut.pending_q !== 4'b1000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL prio_after_ret: pending=%b busy=%b, required 1000 0", dut.pending_q, busy);
    end
    tick();
    total++;
    if (intr !== 1'b1 || intrCause !== 32'd3) begin
      bad++;
      $display("FAIL prio_second: intr=%b cause=%0d, required 1 3", intr, intrCause);
    end
    tick();
    memInstOpcode = OP_RETURN;
    tick();
    memInstOpcode = OP_NOP;
    quiet_lines();
  endtask

  task automatic test_disabled();
    bit seen = 1'b0;
    intrEnable = 1'b0;
    irqLines = 4'b0001;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (intr !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL disabled_hold: activity while disabled, required intr=0 busy=0");
    end
    total++;
    if (dut.pending_q !== 4'b0001) begin
      bad++;
      $display("FAIL disabled_pending: got %b, required 0001", dut.pending_q);
    end
    intrEnable = 1'b1;
    tick();
    total++;
    if (intr !== 1'b1 || intrCause !== 32'd0) begin
      bad++;
      $display("FAIL disabled_enable: intr=%b cause=%0d, required 1 0", intr, intrCause);
    end
    tick();
    memInstOpcode = OP_RETURN;
    tick();
    memInstOpcode = OP_NOP;
    quiet_lines();
  endtask

  task automatic test_mid_service();
    bit moved = 1'b0;
    irqLines = 4'b0100;
    tick();
    tick();
    tick();
    total++;
    if (intr !== 1'b1 || intrCause !== 32'd2) begin
      bad++;
      $display("FAIL mid_first: intr=%b cause=%0d, required 1 2", intr, intrCause);
    end
    tick();
    irqLines = 4'b0101;
    tick();
    irqLines = 4'b0100;
    memInstOpcode = OP_HALT;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (busy !== 1'b1 || intr !== 1'b0 || intrCause !== 32'd2) moved = 1'b1;
    end
    total++;
    if (moved) begin
      bad++;
      $display("FAIL mid_halt: busy=%b intr=%b cause=%0d, required 1 0 2", busy, intr, intrCause);
    end
    memInstOpcode = OP_RETURN;
    tick();
    memInstOpcode = OP_NOP;
    total++;
    if (dut.pending_q !== 4'b0001 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_return: pending=%b busy=%b, required 0001 0", dut.pending_q, busy);
    end
    tick();
    total++;
    if (intr !== 1'b1 || intrCause !== 32'd0) begin
      bad++;
      $display("FAIL mid_next: intr=%b cause=%0d, required 1 0", intr, intrCause);
    end
    tick();
    memInstOpcode = OP_RETURN;
    tick();
    memInstOpcode = OP_NOP;
    quiet_lines();
  endtask

  task automatic test_set_wins();
    irqLines = 4'b0001;
    tick();
    tick();
    tick();
    tick();
    irqLines = 4'b0000;
    tick();
    irqLines = 4'b0001;
    tick();
    memInstOpcode = OP_RETURN;
    tick();
    memInstOpcode = OP_NOP;
    total++;
    if (dut.pending_q !== 4'b0001 || busy !== 1'b0) begin
      bad++;
      $display("FAIL set_wins: pending=%b busy=%b, required 0001 0", dut.pending_q, busy);
    end
    tick();
    total++;
    if (intr !== 1'b1 || intrCause !== 32'd0) begin
      bad++;
      $display("FAIL set_wins_req: intr=%b cause=%0d, required 1 0", intr, intrCause);
    end
    tick();
    memInstOpcode = OP_RETURN;
    tick();
    memInstOpcode = OP_NOP;
    quiet_lines();
  endtask

  task automatic test_reset_in_service();
    int cyc;
    bit again = 1'b0;
    irqLines = 4'b1111;
    wait_intr(8, cyc);
    total++;
    if (cyc != 3) begin
      bad++;
      $display("FAIL rst_svc_latency: got %0d cycles, required 3", cyc);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || intr !== 1'b0 || intrCause !== 32'd0) begin
      bad++;
      $display("FAIL rst_svc_state: busy=%b intr=%b cause=%0d, required 0 0 0", busy, intr, intrCause);
    end
    for (int n = 0; n < 8; n++) begin
      tick();
      if (intr !== 1'b0) again = 1'b1;
    end
    total++;
    if (again || dut.pending_q !== 4'b0000) begin
      bad++;
      $display("FAIL rst_svc_quiet: intr seen=%b pending=%b, required 0 0000", again, dut.pending_q);
    end
    quiet_lines();
  endtask

`ifdef INTR_REQUESTER_MASK_EN
  task automatic test_mask();
    int cyc;
    bit seen = 1'b0;
    maskData = 4'b1110;
    maskWrite = 1'b1;
    tick();
    maskWrite = 1'b0;
    irqLines = 4'b0001;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (intr !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen || dut.pending_q !== 4'b0001) begin
      bad++;
      $display("FAIL mask_block: intr seen=%b pending=%b, required 0 0001", seen, dut.pending_q);
    end
    maskData = 4'b1111;
    maskWrite = 1'b1;
    tick();
    maskWrite = 1'b0;
    wait_intr(4, cyc);
    total++;
    if (cyc < 0 || intrCause !== 32'd0) begin
      bad++;
      $display("FAIL mask_open: wait=%0d cause=%0d, required intr with cause 0", cyc, intrCause);
    end
    tick();
    memInstOpcode = OP_RETURN;
    tick();
    memInstOpcode = OP_NOP;
    quiet_lines();
  endtask
`endif

  initial begin
`ifdef INTR_REQUESTER_MASK_EN
    maskData = '1;
    maskWrite = 1'b0;
`endif
    test_reset();
    test_single();
    test_priority();
    test_disabled();
    test_mid_service();
    test_set_wins();
    test_reset_in_service();
`ifdef INTR_REQUESTER_MASK_EN
    test_mask();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
